snow_flakes: RTL and testbench

- Pixel painter stage between the display timing generator and the VGA output registers.
- Holds positions of N falling snowflakes and composites them as solid white squares over an upstream background colour.
- Updates all flake positions once per frame, in vertical blanking, using a pseudo-random sequence.
- Output is registered: the top level delays hsync/vsync/de by one extra cycle to align with it.

---
 rtl/snow_pkg.sv | 16 +
 rtl/lfsr16.sv | 29 ++
 rtl/snow_flakes.sv | 166 ++++++++++++++++
 tb/tb_snow_flakes.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/snow_pkg.sv
// Shared types and constants for the snowflake painter.
package snow_pkg;

    localparam int CORDW_DEF = 10;

    typedef logic [CORDW_DEF-1:0] coord_t;

    typedef enum logic [0:0] {
        IDLE,
        UPDATE
    } state_t;

    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam logic [3:0]  SNOW_COLOUR = 4'hF;

endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR; reset loads the seed, steps once per enabled cycle.
module lfsr16
    import snow_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_d;

    always_comb begin
        q_d = q;
        if (en) begin
            q_d = {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= seed;
        end else begin
            q <= q_d;
        end
    end

endmodule

// File: rtl/snow_flakes.sv
// Composites N falling snowflakes over the background and moves them once per frame.
// Optional sideways drift on non-respawn updates is enabled by defining SNOW_DRIFT_EN.
module snow_flakes
    import snow_pkg::*;
#(
    parameter int unsigned CORDW    = 10,
    parameter int unsigned H_RES    = 640,
    parameter int unsigned V_RES    = 480,
    parameter int unsigned N_FLAKES = 16,
    parameter int unsigned FLAKE_SZ = 2,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic             frame,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             de,
    input  logic [3:0]       bg_r,
    input  logic [3:0]       bg_g,
    input  logic [3:0]       bg_b,
    output logic [3:0]       paint_r,
    output logic [3:0]       paint_g,
    output logic [3:0]       paint_b,
    output logic             busy
);

    localparam int unsigned IDXW = (N_FLAKES > 1) ? $clog2(N_FLAKES) : 1;
    localparam logic [IDXW-1:0]  LAST  = IDXW'(N_FLAKES - 1);
    localparam logic [CORDW:0]   V_W   = (CORDW+1)'(V_RES);
    localparam logic [CORDW:0]   FS_W  = (CORDW+1)'(FLAKE_SZ);
    localparam logic [CORDW:0]   X_OFF = (CORDW+1)'((H_RES - 512) / 2);
    localparam logic [CORDW:0]   ONE_W = (CORDW+1)'(1);
`ifdef SNOW_DRIFT_EN
    localparam logic [CORDW-1:0] H_MAX = CORDW'(H_RES - 1);
    localparam logic [CORDW-1:0] ONE   = CORDW'(1);
`endif

    function automatic logic [CORDW-1:0] x_init(int unsigned i);
        return CORDW'(i * (H_RES / N_FLAKES) + H_RES / (2 * N_FLAKES));
    endfunction

    function automatic logic [CORDW-1:0] y_init(int unsigned i);
        return CORDW'(i * (V_RES / N_FLAKES));
    endfunction

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [15:0]       lfsr_q;
    logic [CORDW-1:0]  x_q [N_FLAKES];
    logic [CORDW-1:0]  y_q [N_FLAKES];
    logic [CORDW-1:0]  upd_x, upd_y;
    logic [CORDW:0]    y_n, x_spawn;
    logic              hit;
    logic [11:0]       paint_q, paint_d;
    logic              unused_lfsr;

    assign unused_lfsr = ^{lfsr_q[15:9], lfsr_q[1:0]};

    lfsr16 u_lfsr (
        .clk  (clk_pix),
        .rst  (rst_pix),
        .en   (busy),
        .seed (SEED),
        .q    (lfsr_q)
    );

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // A frame pulse while UPDATE is running falls through unused.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (frame) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end
            end
            UPDATE: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == UPDATE);
    end

    always_comb begin
        y_n     = {1'b0, y_q[idx_q]} + ONE_W + (CORDW+1)'(lfsr_q[2]);
        x_spawn = (CORDW+1)'(lfsr_q[8:0]) + X_OFF;
        upd_x   = x_q[idx_q];
        upd_y   = y_n[CORDW-1:0];
        if (y_n >= V_W) begin
            upd_y = '0;
            upd_x = x_spawn[CORDW-1:0];
        end else begin
`ifdef SNOW_DRIFT_EN
            if (lfsr_q[1:0] == 2'b00) begin
                upd_x = (x_q[idx_q] == '0) ? H_MAX : x_q[idx_q] - ONE;
            end else if (lfsr_q[1:0] == 2'b01) begin
                upd_x = (x_q[idx_q] == H_MAX) ? '0 : x_q[idx_q] + ONE;
            end
`endif
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            for (int i = 0; i < N_FLAKES; i++) begin
                x_q[i] <= x_init(i);
                y_q[i] <= y_init(i);
            end
        end else if (busy) begin
            x_q[idx_q] <= upd_x;
            y_q[idx_q] <= upd_y;
        end
    end

    always_comb begin
        logic [CORDW:0] dx, dy;
        hit = 1'b0;
        for (int i = 0; i < N_FLAKES; i++) begin
            dx = {1'b0, sx} - {1'b0, x_q[i]};
            dy = {1'b0, sy} - {1'b0, y_q[i]};
            if (sx >= x_q[i] && dx < FS_W && sy >= y_q[i] && dy < FS_W) begin
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        paint_d = '0;
        if (de) begin
            paint_d = hit ? {SNOW_COLOUR, SNOW_COLOUR, SNOW_COLOUR} : {bg_r, bg_g, bg_b};
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            paint_q <= '0;
        end else begin
            paint_q <= paint_d;
        end
    end

    assign paint_r = paint_q[11:8];
    assign paint_g = paint_q[7:4];
    assign paint_b = paint_q[3:0];

endmodule

// File: tb/tb_snow_flakes.sv
// Directed plus randomized checks of snow_flakes against a frame-level flake model.
module tb_snow_flakes;

    localparam int NF = 16;
    localparam int HR = 640;
    localparam int VR = 480;
    localparam int FS = 2;

    logic             clk_pix = 1'b0;
    logic             rst_pix = 1'b1;
    logic             frame   = 1'b0;
    logic             de      = 1'b0;
    snow_pkg::coord_t sx      = '0;
    snow_pkg::coord_t sy      = '0;
    logic [3:0]       bg_r = '0, bg_g = '0, bg_b = '0;
    logic [3:0]       paint_r, paint_g, paint_b;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    int mx [NF];
    int my [NF];
    int ml;

    always #5 clk_pix = ~clk_pix;

    snow_flakes dut (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .frame   (frame),
        .sx      (sx),
        .sy      (sy),
        .de      (de),
        .bg_r    (bg_r),
        .bg_g    (bg_g),
        .bg_b    (bg_b),
        .paint_r (paint_r),
        .paint_g (paint_g),
        .paint_b (paint_b),
        .busy    (busy)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int lfsr_step(input int l);
        return (l >> 1) ^ (((l & 1) != 0) ? 32'hB400 : 32'h0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NF; i++) begin
            mx[i] = i * (HR / NF) + HR / (2 * NF);
            my[i] = i * (VR / NF);
        end
        ml = 32'hACE1;
    endtask

    // One frame's worth of movement: flakes visited in order, one LFSR step each.
    task automatic model_update();
        int yn;
        for (int i = 0; i < NF; i++) begin
            yn = my[i] + 1 + ((ml >> 2) & 1);
            if (yn >= VR) begin
                my[i] = 0;
                mx[i] = (ml & 511) + (HR - 512) / 2;
            end else begin
                my[i] = yn;
`ifdef SNOW_DRIFT_EN
                if ((ml & 3) == 0) mx[i] = (mx[i] == 0) ? HR - 1 : mx[i] - 1;
                else if ((ml & 3) == 1) mx[i] = (mx[i] + 1) % HR;
`endif
            end
            ml = lfsr_step(ml);
        end
    endtask

    function automatic bit model_hit(input int px, input int py);
        for (int i = 0; i < NF; i++) begin
            if (px >= mx[i] && px < mx[i] + FS && py >= my[i] && py < my[i] + FS) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic probe(input string tag, input int px, input int py, input bit pde,
                         input logic [11:0] bg);
        logic [11:0] exp;
        @(negedge clk_pix);
        sx = 10'(px);
        sy = 10'(py);
        de = pde;
        {bg_r, bg_g, bg_b} = bg;
        exp = !pde ? 12'h000 : (model_hit(px, py) ? 12'hFFF : bg);
        @(posedge clk_pix);
        #1;
        check(tag, {4'h0, paint_r, paint_g, paint_b}, {4'h0, exp});
    endtask

    task automatic check_flakes(input string tag);
        int px, py;
        for (int i = 0; i < NF; i++) begin
            probe(tag, mx[i], my[i], 1'b1, 12'($urandom));
            px = (mx[i] + HR + int'($urandom_range(0, 3)) - 1) % HR;
            py = (my[i] + VR + int'($urandom_range(0, 3)) - 1) % VR;
            probe(tag, px, py, 1'($urandom), 12'($urandom));
        end
    endtask

    // Pulse frame and check busy is high for exactly NF cycles; optionally re-pulse mid-update.
    task automatic run_update(input int retrig_at);
        @(negedge clk_pix);
        frame = 1'b1;
        @(posedge clk_pix);
        #1;
        frame = 1'b0;
        for (int k = 1; k <= NF + 1; k++) begin
            check("busy_window", {15'h0, busy}, {15'h0, (k <= NF) ? 1'b1 : 1'b0});
            frame = (k == retrig_at);
            @(posedge clk_pix);
            #1;
        end
        frame = 1'b0;
    endtask

    task automatic quick_frame();
        @(negedge clk_pix);
        frame = 1'b1;
        @(negedge clk_pix);
        frame = 1'b0;
        repeat (NF + 1) @(negedge clk_pix);
    endtask

    initial begin
        int prev15;
        bit resp_seen;

        model_reset();
        repeat (3) @(posedge clk_pix);
        @(negedge clk_pix);
        rst_pix = 1'b0;
        #1;
        check("reset_paint", {4'h0, paint_r, paint_g, paint_b}, 16'h0000);
        check("reset_busy", {15'h0, busy}, 16'h0000);
        probe("reset_flake0", 20, 0, 1'b1, 12'h123);

        probe("background", 5, 5, 1'b1, 12'h123);
        probe("blanking", 20, 0, 1'b0, 12'h123);
        probe("flake_edge_x", 22, 0, 1'b1, 12'h456);
        probe("flake15_reset", 621, 451, 1'b1, 12'h789);

        run_update(0);
        model_update();
        probe("flake0_moved", 20, my[0], 1'b1, 12'h321);
        probe("flake0_old_row", 20, 0, 1'b1, 12'h321);
        check_flakes("first_update");

        run_update(5);
        model_update();
        check_flakes("retrigger");

        resp_seen = 1'b0;
        for (int f = 0; f < 2000; f++) begin
            prev15 = my[NF-1];
            quick_frame();
            model_update();
            if (!resp_seen && my[NF-1] < prev15) begin
                resp_seen = 1'b1;
                probe("respawn_flake15", mx[NF-1], my[NF-1], 1'b1, 12'h0A5);
                check_flakes("respawn");
            end
            if (f % 250 == 249) check_flakes("long_run");
        end

        @(negedge clk_pix);
        sx = 10'd5;
        sy = 10'd5;
        de = 1'b1;
        {bg_r, bg_g, bg_b} = 12'h777;
        frame = 1'b1;
        @(posedge clk_pix);
        #1;
        frame = 1'b0;
        repeat (7) @(posedge clk_pix);
        #1;
        check("busy_before_reset", {15'h0, busy}, 16'h0001);
        rst_pix = 1'b1;
        #1;
        check("reset_mid_busy", {15'h0, busy}, 16'h0000);
        check("reset_mid_paint", {4'h0, paint_r, paint_g, paint_b}, 16'h0000);
        @(negedge clk_pix);
        rst_pix = 1'b0;
        model_reset();
        check_flakes("after_mid_reset");
        run_update(0);
        model_update();
        check_flakes("update_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
